// File: rtl/uart_pkg.sv
// Shared UART constants, receiver state encoding and the received-byte payload.
package uart_pkg;

    localparam int unsigned OVERSAMPLE   = 16;
    localparam int unsigned SAMPLE_POINT = 7;
    localparam int unsigned DATA_BITS    = 8;
    localparam int unsigned SCNT_W       = $clog2(OVERSAMPLE);
    localparam int unsigned BIDX_W       = $clog2(DATA_BITS);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_t;

    typedef struct packed {
        logic [DATA_BITS-1:0] data;
        logic                 parity_err;
        logic                 frame_err;
        logic                 brk;
    } rx_result_t;

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-cycle tick every max(div_i,1) clocks while enabled.
module uart_baud_tick #(
    parameter int unsigned DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic [DIV_W-1:0] div_i,
    output logic             tick_c
);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] reload_c;

    // A divisor of zero behaves like one (tick every clock).
    assign reload_c = (div_i == '0) ? '0 : div_i - DIV_W'(1);
    assign tick_c   = en_i && (cnt_q == '0);

    always_comb begin
        cnt_d = cnt_q;
        if (!en_i || cnt_q == '0) begin
            cnt_d = reload_c;
        end else begin
            cnt_d = cnt_q - DIV_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx_engine.sv
// UART receiver: 16x oversampled frame recovery with parity/stop checks and a valid/ready output.
// Optional build macro UART_RX_MAJORITY_EN: 2-of-3 majority vote over ticks 6, 7 and 8.
module uart_rx_engine
    import uart_pkg::*;
#(
    parameter int unsigned BAUD_W = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              rx_en,
    input  logic [BAUD_W-1:0] baud_div,
    input  logic              parity_enable,
    input  logic              parity_odd,
    input  logic              stop_bit,
    input  logic              rx,
    output logic [7:0]        rx_data,
    output logic              rx_parity_err,
    output logic              rx_frame_err,
    output logic              rx_break,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              overrun_err,
    output logic              busy
);

`ifdef UART_RX_MAJORITY_EN
    localparam int unsigned DECIDE_PT = SAMPLE_POINT + 1;
`else
    localparam int unsigned DECIDE_PT = SAMPLE_POINT;
`endif

    logic              sync1_q, sync2_q, prev_q;
    rx_state_t         state_q, state_d;
    logic [SCNT_W-1:0] scnt_q, scnt_d;
    logic [BIDX_W-1:0] bidx_q, bidx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic              pen_q, pen_d, podd_q, podd_d, two_q, two_d;
    logic              stop2_q, stop2_d, perr_q, perr_d, ferr_q, ferr_d;
    rx_result_t        res_q, res_d;
    logic              valid_q, valid_d, ovr_q, ovr_d, busy_q, busy_d;
    logic              tick_c, bit_c, sample_c, wrap_c, done_c, hs_c;

    uart_baud_tick #(.DIV_W(BAUD_W)) u_baud_tick (
        .clk    (clock),
        .rst_n  (reset),
        .en_i   (rx_en && (state_q != IDLE)),
        .div_i  (baud_div),
        .tick_c (tick_c)
    );

    assign sample_c = tick_c && (scnt_q == SCNT_W'(DECIDE_PT));
    assign wrap_c   = tick_c && (scnt_q == SCNT_W'(OVERSAMPLE - 1));

`ifdef UART_RX_MAJORITY_EN
    logic s6_q, s7_q;

    // Early samples held for the vote taken at the decision tick.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s6_q <= 1'b0;
            s7_q <= 1'b0;
        end else if (tick_c) begin
            if (scnt_q == SCNT_W'(SAMPLE_POINT - 1)) s6_q <= sync2_q;
            if (scnt_q == SCNT_W'(SAMPLE_POINT))     s7_q <= sync2_q;
        end
    end

    assign bit_c = (s6_q & s7_q) | (s6_q & sync2_q) | (s7_q & sync2_q);
`else
    assign bit_c = sync2_q;
`endif

    always_comb begin
        state_d = state_q;
        scnt_d  = tick_c ? scnt_q + SCNT_W'(1) : scnt_q;
        bidx_d  = bidx_q;
        shift_d = shift_q;
        pen_d   = pen_q;
        podd_d  = podd_q;
        two_d   = two_q;
        stop2_d = stop2_q;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        done_c  = 1'b0;

        if (!rx_en) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    scnt_d  = '0;
                    bidx_d  = '0;
                    stop2_d = 1'b0;
                    perr_d  = 1'b0;
                    ferr_d  = 1'b0;
                    if (prev_q && !sync2_q) begin
                        state_d = START;
                        pen_d   = parity_enable;
                        podd_d  = parity_odd;
                        two_d   = stop_bit;
                    end
                end
                START: begin
                    if (sample_c && bit_c) begin
                        state_d = IDLE;
                    end else if (wrap_c) begin
                        state_d = DATA;
                    end
                end
                DATA: begin
                    if (sample_c) shift_d = {bit_c, shift_q[DATA_BITS-1:1]};
                    if (wrap_c) begin
                        bidx_d = bidx_q + BIDX_W'(1);
                        if (bidx_q == BIDX_W'(DATA_BITS - 1)) begin
                            state_d = pen_q ? PARITY : STOP;
                        end
                    end
                end
                PARITY: begin
                    if (sample_c && (bit_c != ((^shift_q) ^ podd_q))) perr_d = 1'b1;
                    if (wrap_c) state_d = STOP;
                end
                STOP: begin
                    if (sample_c) begin
                        if (!bit_c) ferr_d = 1'b1;
                        // The frame ends mid-stop so the next start edge is seen.
                        if (!two_q || stop2_q) begin
                            done_c  = 1'b1;
                            state_d = IDLE;
                        end else begin
                            stop2_d = 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // Output holding register with overrun detection.
        hs_c    = valid_q && rx_ready;
        res_d   = res_q;
        valid_d = valid_q && !hs_c;
        ovr_d   = 1'b0;
        if (done_c) begin
            if (!valid_q || hs_c) begin
                res_d.data       = shift_q;
                res_d.parity_err = perr_d;
                res_d.frame_err  = ferr_d;
                res_d.brk        = ferr_d && (shift_q == '0);
                valid_d          = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
            state_q <= IDLE;
            scnt_q  <= '0;
            bidx_q  <= '0;
            shift_q <= '0;
            pen_q   <= 1'b0;
            podd_q  <= 1'b0;
            two_q   <= 1'b0;
            stop2_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            res_q   <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            sync1_q <= rx;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            state_q <= state_d;
            scnt_q  <= scnt_d;
            bidx_q  <= bidx_d;
            shift_q <= shift_d;
            pen_q   <= pen_d;
            podd_q  <= podd_d;
            two_q   <= two_d;
            stop2_q <= stop2_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            res_q   <= res_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
            busy_q  <= busy_d;
        end
    end

    assign rx_data       = res_q.data;
    assign rx_parity_err = res_q.parity_err;
    assign rx_frame_err  = res_q.frame_err;
    assign rx_break      = res_q.brk;
    assign rx_valid      = valid_q;
    assign overrun_err   = ovr_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_uart_rx_engine.sv
// Directed bench for uart_rx_engine with a queue of expected received bytes.
module tb_uart_rx_engine;

    localparam int DIV = 4;
    localparam int BIT = 16 * DIV;

    typedef struct packed {
        logic [7:0] d;
        logic       p;
        logic       f;
        logic       b;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        rx_en;
    logic [15:0] baud_div;
    logic        parity_enable, parity_odd, stop_bit;
    logic        rx;
    logic [7:0]  rx_data;
    logic        rx_parity_err, rx_frame_err, rx_break, rx_valid;
    logic        rx_ready;
    logic        overrun_err, busy;

    int   errors = 0;
    int   checks = 0;
    int   ovr_cnt = 0;
    int   rise_cnt = 0;
    logic valid_prev = 1'b0;
    exp_t exp_q[$];

    uart_rx_engine #(.BAUD_W(16)) dut (
        .clock         (clock),
        .reset         (reset),
        .rx_en         (rx_en),
        .baud_div      (baud_div),
        .parity_enable (parity_enable),
        .parity_odd    (parity_odd),
        .stop_bit      (stop_bit),
        .rx            (rx),
        .rx_data       (rx_data),
        .rx_parity_err (rx_parity_err),
        .rx_frame_err  (rx_frame_err),
        .rx_break      (rx_break),
        .rx_valid      (rx_valid),
        .rx_ready      (rx_ready),
        .overrun_err   (overrun_err),
        .busy          (busy)
    );

    always #5 clock = ~clock;

    // Event counters for pulses the main sequence cannot watch continuously.
    always @(negedge clock) begin
        if (overrun_err === 1'b1) ovr_cnt++;
        if (rx_valid === 1'b1 && valid_prev !== 1'b1) rise_cnt++;
        valid_prev = rx_valid;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input logic [7:0] d, input logic pen, input logic podd,
                            input logic two, input logic pbit, input logic s1, input logic s2);
        exp_t e;
        e.d = d;
        e.p = pen && (pbit != ((^d) ^ podd));
        e.f = !s1 || (two && !s2);
        e.b = e.f && (d == 8'h00);
        exp_q.push_back(e);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic pen, input logic podd,
                              input logic two, input logic pbit, input logic s1, input logic s2);
        parity_enable = pen;
        parity_odd    = podd;
        stop_bit      = two;
        rx = 1'b0;
        repeat (BIT) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (BIT) @(negedge clock);
        end
        if (pen) begin
            rx = pbit;
            repeat (BIT) @(negedge clock);
        end
        rx = s1;
        repeat (BIT) @(negedge clock);
        if (two) begin
            rx = s2;
            repeat (BIT) @(negedge clock);
        end
        rx = 1'b1;
        repeat (4) @(negedge clock);
    endtask

    task automatic check_next(input string tag, input int max_cyc, input int lo, input int hi);
        exp_t e;
        int   c;
        bit   got;
        c   = 0;
        got = 1'b0;
        while (!got && c < max_cyc) begin
            @(negedge clock);
            c++;
            if (rx_valid === 1'b1) got = 1'b1;
        end
        chk({tag, "_valid"}, 32'(got), 32'd1);
        chk({tag, "_queued"}, 32'(exp_q.size() > 0), 32'd1);
        if (got && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({tag, "_data"},  32'(rx_data), 32'(e.d));
            chk({tag, "_perr"},  32'(rx_parity_err), 32'(e.p));
            chk({tag, "_ferr"},  32'(rx_frame_err), 32'(e.f));
            chk({tag, "_break"}, 32'(rx_break), 32'(e.b));
            if (hi > 0) chk({tag, "_latency"}, 32'(c >= lo && c <= hi), 32'd1);
        end
    endtask

    task automatic xfer(input string tag, input logic [7:0] d, input logic pen, input logic podd,
                        input logic two, input logic pbit, input logic s1, input logic s2,
                        input int lo, input int hi);
        push_exp(d, pen, podd, two, pbit, s1, s2);
        fork
            send_frame(d, pen, podd, two, pbit, s1, s2);
            check_next(tag, 16 * BIT, lo, hi);
        join
    endtask

    initial begin
        int r0;
        int o0;
        reset         = 1'b0;
        rx_en         = 1'b1;
        baud_div      = 16'(DIV);
        parity_enable = 1'b0;
        parity_odd    = 1'b0;
        stop_bit      = 1'b0;
        rx            = 1'b1;
        rx_ready      = 1'b1;
        repeat (3) @(negedge clock);

        chk("rst_valid", 32'(rx_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_data", 32'(rx_data), 32'd0);
        chk("rst_flags", 32'({rx_parity_err, rx_frame_err, rx_break}), 32'd0);
        chk("rst_overrun", 32'(overrun_err), 32'd0);
        reset = 1'b1;
        repeat (4) @(negedge clock);

        // Basic frame with latency window around 2 sync + 9.5 bit times.
        xfer("a5", 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 600, 620);
        chk("a5_consumed", 32'(rx_valid), 32'd0);

        xfer("par_even", 8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 0, 0);
        xfer("par_odd",  8'h3C, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 0, 0);
        xfer("par_ok",   8'h96, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0, 0);

        xfer("brk",      8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0);
        xfer("two_stop", 8'h81, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0, 0);
        xfer("two_ok",   8'h7E, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 0, 0);

        // Five-tick low glitch must abort at the start-bit sample.
        r0 = rise_cnt;
        rx = 1'b0;
        repeat (5 * DIV) @(negedge clock);
        chk("glitch_busy", 32'(busy), 32'd1);
        rx = 1'b1;
        repeat (3 * BIT) @(negedge clock);
        #1;
        chk("glitch_idle", 32'(busy), 32'd0);
        chk("glitch_novalid", 32'(rx_valid), 32'd0);
        chk("glitch_norise", 32'(rise_cnt), 32'(r0));

        // Overrun: second byte dropped while first is held.
        rx_ready = 1'b0;
        xfer("ovr_first", 8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0, 0);
        o0 = ovr_cnt;
        send_frame(8'h22, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        #1;
        chk("ovr_pulse", 32'(ovr_cnt), 32'(o0 + 1));
        chk("ovr_held_data", 32'(rx_data), 32'h11);
        chk("ovr_held_valid", 32'(rx_valid), 32'd1);
        rx_ready = 1'b1;
        @(negedge clock);
        chk("ovr_release", 32'(rx_valid), 32'd0);

        // Asynchronous reset in the middle of a frame.
        rx = 1'b0;
        repeat (3 * BIT) @(negedge clock);
        chk("mid_busy", 32'(busy), 32'd1);
        reset = 1'b0;
        #1;
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_valid", 32'(rx_valid), 32'd0);
        chk("mrst_data", 32'(rx_data), 32'd0);
        rx = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        repeat (4) @(negedge clock);
        xfer("after_rst", 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0, 0);

        // Receiver disabled mid-frame keeps the held byte.
        rx_ready = 1'b0;
        xfer("held", 8'hC3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0, 0);
        o0 = ovr_cnt;
        rx = 1'b0;
        repeat (2 * BIT) @(negedge clock);
        rx_en = 1'b0;
        @(negedge clock);
        #1;
        chk("en_busy", 32'(busy), 32'd0);
        chk("en_valid", 32'(rx_valid), 32'd1);
        chk("en_data", 32'(rx_data), 32'hC3);
        rx = 1'b1;
        repeat (12 * BIT) @(negedge clock);
        #1;
        chk("en_noovr", 32'(ovr_cnt), 32'(o0));
        chk("en_still_idle", 32'(busy), 32'd0);
        rx_en = 1'b1;
        rx_ready = 1'b1;
        @(negedge clock);
        chk("en_release", 32'(rx_valid), 32'd0);
        repeat (4) @(negedge clock);
        xfer("after_en", 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_engine.md
# uart_rx_engine

Serial-line receiver for the UART: recovers frames from the `rx` pin using 16× oversampling, checks parity and stop bits, and presents each received byte on a valid/ready port feeding the RX FIFO. It is the receiving end of the same frame format the UART transmit path drives: 1 start bit, 8 data bits LSB-first, optional parity, 1 or 2 stop bits. Configuration inputs come from the UART control register and are sampled only in IDLE.

## Interface
- `BAUD_W`, default 16: width of the baud divisor.
- `clock`  in  1  system clock, all logic on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `rx_en`  in  1  receiver enable; low forces IDLE.
- `baud_div`  in  BAUD_W  clocks per oversample tick; 0 is treated as 1.
- `parity_enable`  in  1  parity bit present after data.
- `parity_odd`  in  1  1 = odd parity, 0 = even.
- `stop_bit`  in  1  0 = one stop bit, 1 = two stop bits.
- `rx`  in  1  asynchronous serial input, idle high.
- `rx_data`  out  8  received byte.
- `rx_parity_err`  out  1  parity mismatch for `rx_data`; valid with `rx_valid`.
- `rx_frame_err`  out  1  a stop bit sampled 0; valid with `rx_valid`.
- `rx_break`  out  1  data all zero and frame error; valid with `rx_valid`.
- `rx_valid`  out  1  `rx_data` and flags hold an unconsumed byte.
- `rx_ready`  in  1  consumer (RX FIFO not full) accepts the byte.
- `overrun_err`  out  1  one-cycle pulse: a frame completed while `rx_valid` was high.
- `busy`  out  1  high in every state except IDLE.

## Operation
- `rx` passes through a 2-flop synchronizer; the flops reset to 1.
- Tick generator: counter reloads at `baud_div-1` and pulses `tick` when it reaches 0. It is held reloaded while `rx_en` is low or the FSM is in IDLE.
- The 4-bit sample counter counts ticks 0..15 within each bit. Wrapping from 15 to 0 ends the bit.
- Bit sample point is tick 7.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: enters START on a falling edge of the synced `rx` (previous 1, current 0) with `rx_en` high. Latches `parity_enable`, `parity_odd` and `stop_bit`. Clears the sample counter.
  - START: at tick 7, if the sample is 1 this is a false start and the FSM returns to IDLE with no output. At the tick-15 wrap it goes to DATA.
  - DATA: shifts the sample in at the MSB, 3-bit bit index. After the 8th wrap it goes to PARITY if parity is enabled, else STOP.
  - PARITY: compares the sample with the XOR of the data, inverted when odd; sets the internal parity flag on mismatch. Goes to STOP on wrap.
  - STOP: samples the stop bit at tick 7; a 0 sets the frame flag.
    - One stop bit: the frame completes at that tick-7 sample.
    - Two stop bits: checks the first bit, wraps, and completes at tick 7 of the second bit.
  - On completion the FSM returns to IDLE. The line is high mid-stop, so back-to-back frames are detected.
- Completion with `rx_valid` low: loads `rx_data` and the flags, and sets `rx_valid`.
- Completion with `rx_valid` high: pulses `overrun_err`. The new byte is dropped and the held byte is unchanged.
- `rx_valid` clears on a clock with `rx_valid && rx_ready`. If completion coincides with that handshake, the new byte loads, `rx_valid` stays high, and there is no overrun.
- `rx_break` = `rx_frame_err` && `rx_data`==0.
- `rx_en` deasserted mid-frame: the FSM goes to IDLE on the next clock, no write, no flags. The held `rx_valid`/`rx_data` are retained.
- Reset values: all outputs 0, FSM in IDLE, counters 0, synchronizer 1.

## Timing
- Bit period is 16×max(`baud_div`,1) clocks.
- `rx_valid` rises on the clock edge after the completing sample tick. Total latency from the pin edge is 2 synchronizer cycles plus the frame time.
- Start detection to first data sample: 24 ticks (start bit plus half a bit).
- `overrun_err` is asserted in the same cycle `rx_valid` would have been set.
- `busy` falls on the clock after completion.

## Configuration
- `UART_RX_MAJORITY_EN` defined: each bit value is the 2-of-3 majority of samples at ticks 6, 7 and 8. Start validation, completion and `rx_valid` timing move to tick 8.
- `UART_RX_MAJORITY_EN` undefined: single sample at tick 7; no sample storage is built.

## Structure
- Package `uart_pkg` holds:
  - the `rx_state_t` enum (IDLE, START, DATA, PARITY, STOP);
  - `OVERSAMPLE` = 16;
  - `SAMPLE_POINT` = 7;
  - `DATA_BITS` = 8.
- Sub-module `uart_baud_tick` holds the divisor counter. It is shared later with the transmit path and runs at 1 tick per 16 for TX.

## Test plan
- `baud_div`=4, no parity, 1 stop, frame 0xA5 -> `rx_data`=0xA5 and `rx_valid`=1 about 600 clocks after the start edge; all error flags 0.
- Even parity, data 0x3C sent with parity bit 1 -> `rx_parity_err`=1, `rx_data`=0x3C. Repeat with odd parity -> error 0.
- Data 0x00 with stop bit 0 -> `rx_frame_err`=1, `rx_break`=1. Two-stop mode with the second stop bit 0 -> `rx_frame_err`=1.
- Low glitch of 5 ticks on an idle line -> false start, `busy` returns to 0, no `rx_valid`.
- `rx_ready`=0, send 0x11 then 0x22 -> one `overrun_err` pulse, `rx_data` stays 0x11. Raising `rx_ready` clears `rx_valid`.
- Mid-frame async reset (and separately `rx_en`=0) -> IDLE and outputs 0 (held byte retained for `rx_en`); the next 0x5A frame is received correctly.
